// File: rtl/alu_pkg.sv
// Shared funct codes, result-mux encodings and sequencer state for alu_op_sequencer.
// Optional divide support is enabled with the ALU_DIVU_EN macro.
package alu_pkg;

    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FN_AND   = 6'd36;
    localparam logic [FUNCT_W-1:0] FN_OR    = 6'd37;
    localparam logic [FUNCT_W-1:0] FN_ADD   = 6'd32;
    localparam logic [FUNCT_W-1:0] FN_SUB   = 6'd34;
    localparam logic [FUNCT_W-1:0] FN_SLT   = 6'd42;
    localparam logic [FUNCT_W-1:0] FN_SRL   = 6'd2;
    localparam logic [FUNCT_W-1:0] FN_MULTU = 6'd25;
    localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'd16;
    localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'd18;
    localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'd27;

    localparam logic [1:0] MUX_ALU   = 2'd0;
    localparam logic [1:0] MUX_HI    = 2'd1;
    localparam logic [1:0] MUX_LO    = 2'd2;
    localparam logic [1:0] MUX_SHIFT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Counter must hold max(cycles)-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Loadable down-counter that tracks the remaining multiply/divide step cycles.
module iter_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_c
);

    assign zero_c = (count == '0);

    // Load wins over decrement; the counter saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero_c) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller sequencing funct-coded ops onto the ALU/shifter/multiplier/HiLo datapath.
// Define ALU_DIVU_EN to sequence DIVU (funct 27) through the DIV state; otherwise it is illegal.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FUNCT_W-1:0] req_funct,
    output logic [FUNCT_W-1:0] alu_ctrl,
    output logic [1:0]         mux_sel,
    output logic               mul_start,
    output logic               mul_step,
    output logic               div_mode,
    output logic               hilo_we,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_wb,
    output logic               rsp_err
);

    localparam int unsigned CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    state_t             state, state_d;
    logic               req_ready_d;
    logic [FUNCT_W-1:0] alu_ctrl_d;
    logic [1:0]         mux_sel_d;
    logic               mul_start_d, mul_step_d, hilo_we_d;
    logic               rsp_valid_d, rsp_wb_d, rsp_err_d;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_load_val, cnt;
    logic               accept;
`ifdef ALU_DIVU_EN
    logic               div_mode_d;
`endif

    assign accept = req_valid && req_ready;

    iter_counter #(.W(CNT_W)) u_iter_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero_c   (cnt_zero)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state;
        alu_ctrl_d   = alu_ctrl;
        mux_sel_d    = mux_sel;
        mul_start_d  = 1'b0;
        mul_step_d   = 1'b0;
        hilo_we_d    = 1'b0;
        rsp_valid_d  = rsp_valid;
        rsp_wb_d     = rsp_wb;
        rsp_err_d    = rsp_err;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef ALU_DIVU_EN
        div_mode_d   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_RESP;
                    alu_ctrl_d  = '0;
                    mux_sel_d   = MUX_ALU;
                    rsp_valid_d = 1'b1;
                    rsp_wb_d    = 1'b1;
                    rsp_err_d   = 1'b0;
                    case (req_funct)
                        FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: alu_ctrl_d = req_funct;
                        FN_SRL:  mux_sel_d = MUX_SHIFT;
                        FN_MFHI: mux_sel_d = MUX_HI;
                        FN_MFLO: mux_sel_d = MUX_LO;
                        FN_MULTU: begin
                            state_d      = ST_MUL;
                            rsp_valid_d  = 1'b0;
                            rsp_wb_d     = 1'b0;
                            mul_start_d  = 1'b1;
                            mul_step_d   = 1'b1;
                            hilo_we_d    = (MUL_CYCLES == 32'd1);
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(MUL_CYCLES - 32'd1);
                        end
`ifdef ALU_DIVU_EN
                        FN_DIVU: begin
                            state_d      = ST_DIV;
                            rsp_valid_d  = 1'b0;
                            rsp_wb_d     = 1'b0;
                            mul_start_d  = 1'b1;
                            mul_step_d   = 1'b1;
                            div_mode_d   = 1'b1;
                            hilo_we_d    = (DIV_CYCLES == 32'd1);
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(DIV_CYCLES - 32'd1);
                        end
`endif
                        default: begin
                            rsp_wb_d  = 1'b0;
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end
            end
            // Step until the count hits zero; HiLo is written on that final step cycle.
            ST_MUL: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_wb_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                end else begin
                    mul_step_d = 1'b1;
                    hilo_we_d  = (cnt == CNT_W'(1));
                end
            end
`ifdef ALU_DIVU_EN
            ST_DIV: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_wb_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                end else begin
                    mul_step_d = 1'b1;
                    div_mode_d = 1'b1;
                    hilo_we_d  = (cnt == CNT_W'(1));
                end
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_wb_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            alu_ctrl  <= '0;
            mux_sel   <= MUX_ALU;
            mul_start <= 1'b0;
            mul_step  <= 1'b0;
            hilo_we   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_wb    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            req_ready <= req_ready_d;
            alu_ctrl  <= alu_ctrl_d;
            mux_sel   <= mux_sel_d;
            mul_start <= mul_start_d;
            mul_step  <= mul_step_d;
            hilo_we   <= hilo_we_d;
            rsp_valid <= rsp_valid_d;
            rsp_wb    <= rsp_wb_d;
            rsp_err   <= rsp_err_d;
        end
    end

`ifdef ALU_DIVU_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            div_mode <= 1'b0;
        end else begin
            div_mode <= div_mode_d;
        end
    end
`else
    assign div_mode = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against a per-transaction timing model.
// DIVU expectations follow the ALU_DIVU_EN macro.
module tb_alu_op_sequencer;

    localparam int unsigned MUL_N = 32;
    localparam int unsigned DIV_N = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_funct;
    logic [5:0] alu_ctrl;
    logic [1:0] mux_sel;
    logic       mul_start, mul_step, div_mode, hilo_we;
    logic       rsp_valid, rsp_ready, rsp_wb, rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_alu;
    logic [1:0] exp_mux;

    alu_op_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_funct (req_funct),
        .alu_ctrl  (alu_ctrl),
        .mux_sel   (mux_sel),
        .mul_start (mul_start),
        .mul_step  (mul_step),
        .div_mode  (div_mode),
        .hilo_we   (hilo_we),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wb    (rsp_wb),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: issue funct, walk the busy window, stall the response, consume it.
    task automatic do_op(input logic [5:0] f, input int stall);
        bit is_mul, is_div, legal, wb;
        int lat;
        is_mul = (f == 6'd25);
`ifdef ALU_DIVU_EN
        is_div = (f == 6'd27);
`else
        is_div = 1'b0;
`endif
        legal = (f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18, 6'd25}) || is_div;
        wb    = legal && !is_mul && !is_div;
        lat   = is_mul ? int'(MUL_N) : (is_div ? int'(DIV_N) : 0);
        exp_alu = (f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42}) ? f : 6'd0;
        exp_mux = (f == 6'd2) ? 2'd3 : (f == 6'd16) ? 2'd1 : (f == 6'd18) ? 2'd2 : 2'd0;

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_funct = f;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;

        for (int k = 1; k <= lat; k++) begin
            check("busy_mul_start", 32'(mul_start), 32'(k == 1));
            check("busy_mul_step",  32'(mul_step), 32'd1);
            check("busy_hilo_we",   32'(hilo_we), 32'(k == lat));
            check("busy_div_mode",  32'(div_mode), 32'(is_div));
            check("busy_rsp_valid", 32'(rsp_valid), 32'd0);
            check("busy_req_ready", 32'(req_ready), 32'd0);
            req_valid = 1'($urandom);
            req_funct = 6'($urandom);
            rsp_ready = 1'($urandom);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;

        check("rsp_valid",     32'(rsp_valid), 32'd1);
        check("rsp_wb",        32'(rsp_wb), 32'(wb));
        check("rsp_err",       32'(rsp_err), 32'(!legal));
        check("rsp_alu_ctrl",  32'(alu_ctrl), 32'(exp_alu));
        check("rsp_mux_sel",   32'(mux_sel), 32'(exp_mux));
        check("rsp_mul_start", 32'(mul_start), 32'd0);
        check("rsp_mul_step",  32'(mul_step), 32'd0);
        check("rsp_hilo_we",   32'(hilo_we), 32'd0);
        check("rsp_div_mode",  32'(div_mode), 32'd0);
        check("rsp_req_ready", 32'(req_ready), 32'd0);

        for (int s = 0; s < stall; s++) begin
            step();
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_wb",    32'(rsp_wb), 32'(wb));
            check("stall_rsp_err",   32'(rsp_err), 32'(!legal));
            check("stall_mux_sel",   32'(mux_sel), 32'(exp_mux));
            check("stall_alu_ctrl",  32'(alu_ctrl), 32'(exp_alu));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_req_ready", 32'(req_ready), 32'd1);
        check("done_mux_hold",  32'(mux_sel), 32'(exp_mux));
        check("done_alu_hold",  32'(alu_ctrl), 32'(exp_alu));
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_alu_ctrl"},  32'(alu_ctrl), 32'd0);
        check({tag, "_mux_sel"},   32'(mux_sel), 32'd0);
        check({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        check({tag, "_mul_step"},  32'(mul_step), 32'd0);
        check({tag, "_div_mode"},  32'(div_mode), 32'd0);
        check({tag, "_hilo_we"},   32'(hilo_we), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_wb"},    32'(rsp_wb), 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Abort a multiply at T+10 and confirm nothing of it survives.
    task automatic reset_mid_mul();
        req_valid = 1'b1;
        req_funct = 6'd25;
        step();
        req_valid = 1'b0;
        repeat (9) step();
        check("pre_reset_step", 32'(mul_step), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_clear("abort");
        exp_alu = 6'd0;
        exp_mux = 2'd0;
        repeat (int'(MUL_N) + 8) begin
            step();
            check("abort_hilo_we",   32'(hilo_we), 32'd0);
            check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        logic [5:0] ops [11];
        logic [5:0] f;
        int idx;
        ops = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18, 6'd27, 6'd7};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_funct = 6'd0;
        rsp_ready = 1'b0;
        repeat (2) step();
        check_all_clear("reset");
        reset = 1'b0;
        step();

        do_op(6'd32, 0);
        do_op(6'd25, 0);
        do_op(6'd18, 0);
        do_op(6'd2, 5);
        do_op(6'd7, 0);
        do_op(6'd27, 1);
        reset_mid_mul();

        for (int n = 0; n < 30; n++) begin
            idx = int'($urandom_range(0, 11));
            f = (idx == 11) ? 6'($urandom) : ops[idx];
            do_op(f, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
